// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory read port and one memory write port among
// NUM_CONSUMERS requesters; define MEM_ARBITER_TIMEOUT_EN to add the per-transaction watchdog.
module mem_arbiter #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int NUM_CONSUMERS  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_CONSUMERS-1:0]                    consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]     consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                    consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]     consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                    consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]     consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]     consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                    consumer_write_ready,
  output logic                                        mem_read_valid,
  output logic [ADDR_BITS-1:0]                        mem_read_address,
  input  logic                                        mem_read_ready,
  input  logic [DATA_BITS-1:0]                        mem_read_data,
  output logic                                        mem_write_valid,
  output logic [ADDR_BITS-1:0]                        mem_write_address,
  output logic [DATA_BITS-1:0]                        mem_write_data,
  input  logic                                        mem_write_ready,
  output logic [$clog2(NUM_CONSUMERS)-1:0]            grant_id,
  output logic                                        busy,
  output logic                                        timeout_error
);

  localparam int ID_BITS = $clog2(NUM_CONSUMERS);

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    READ_RELAY,
    WRITE_RELAY
  } state_e;

  state_e                                   state_q, state_d;
  logic [ID_BITS-1:0]                       rr_ptr_q, rr_ptr_d;
  logic [ID_BITS-1:0]                       grant_q, grant_d;
  logic                                     busy_q, busy_d;
  logic                                     mem_rd_vld_q, mem_rd_vld_d;
  logic [ADDR_BITS-1:0]                     mem_rd_addr_q, mem_rd_addr_d;
  logic                                     mem_wr_vld_q, mem_wr_vld_d;
  logic [ADDR_BITS-1:0]                     mem_wr_addr_q, mem_wr_addr_d;
  logic [DATA_BITS-1:0]                     mem_wr_data_q, mem_wr_data_d;
  logic [NUM_CONSUMERS-1:0]                 cons_rd_rdy_q, cons_rd_rdy_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  cons_rd_data_q, cons_rd_data_d;
  logic [NUM_CONSUMERS-1:0]                 cons_wr_rdy_q, cons_wr_rdy_d;

  logic                                     found;
  logic [ID_BITS-1:0]                       winner;
  logic [ID_BITS-1:0]                       scan_idx;
  logic [ID_BITS-1:0]                       winner_next;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_err_q, tmo_err_d;
  logic        tmo_hit;

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);
`endif

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      scan_idx = ID_BITS'((int'(rr_ptr_q) + i) % NUM_CONSUMERS);
      if (!found && (consumer_read_valid[scan_idx] || consumer_write_valid[scan_idx])) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
    winner_next = (int'(winner) == NUM_CONSUMERS - 1) ? '0 : winner + ID_BITS'(1);
  end

  always_comb begin
    // NOTE: every next-state value gets a hold default first, so no path through the case
    // leaves a variable unassigned and no latch is inferred.
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_d        = grant_q;
    mem_rd_vld_d   = mem_rd_vld_q;
    mem_rd_addr_d  = mem_rd_addr_q;
    mem_wr_vld_d   = mem_wr_vld_q;
    mem_wr_addr_d  = mem_wr_addr_q;
    mem_wr_data_d  = mem_wr_data_q;
    cons_rd_rdy_d  = cons_rd_rdy_q;
    cons_rd_data_d = cons_rd_data_q;
    cons_wr_rdy_d  = cons_wr_rdy_q;
`ifdef MEM_ARBITER_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
    tmo_err_d      = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = winner;
          rr_ptr_d = winner_next;
`ifdef MEM_ARBITER_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
          // Read wins when one consumer asserts both valids; the write stays pending.
          if (consumer_read_valid[winner]) begin
            state_d       = READ_WAIT;
            mem_rd_vld_d  = 1'b1;
            mem_rd_addr_d = consumer_read_address[winner];
          end else begin
            state_d       = WRITE_WAIT;
            mem_wr_vld_d  = 1'b1;
            mem_wr_addr_d = consumer_write_address[winner];
            mem_wr_data_d = consumer_write_data[winner];
          end
        end
      end

      READ_WAIT: begin
`ifdef MEM_ARBITER_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
        if (mem_read_ready) begin
          mem_rd_vld_d            = 1'b0;
          cons_rd_data_d[grant_q] = mem_read_data;
          cons_rd_rdy_d[grant_q]  = 1'b1;
          state_d                 = READ_RELAY;
        end
`ifdef MEM_ARBITER_TIMEOUT_EN
        else if (tmo_hit) begin
          mem_rd_vld_d            = 1'b0;
          cons_rd_data_d[grant_q] = '0;
          cons_rd_rdy_d[grant_q]  = 1'b1;
          tmo_err_d               = 1'b1;
          state_d                 = READ_RELAY;
        end
`endif
      end

      WRITE_WAIT: begin
`ifdef MEM_ARBITER_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
        if (mem_write_ready) begin
          mem_wr_vld_d           = 1'b0;
          cons_wr_rdy_d[grant_q] = 1'b1;
          state_d                = WRITE_RELAY;
        end
`ifdef MEM_ARBITER_TIMEOUT_EN
        else if (tmo_hit) begin
          mem_wr_vld_d           = 1'b0;
          cons_wr_rdy_d[grant_q] = 1'b1;
          tmo_err_d              = 1'b1;
          state_d                = WRITE_RELAY;
        end
`endif
      end

      READ_RELAY: begin
        if (!consumer_read_valid[grant_q]) begin
          cons_rd_rdy_d[grant_q] = 1'b0;
          state_d                = IDLE;
        end
      end

      WRITE_RELAY: begin
        if (!consumer_write_valid[grant_q]) begin
          cons_wr_rdy_d[grant_q] = 1'b0;
          state_d                = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      grant_q        <= '0;
      busy_q         <= 1'b0;
      mem_rd_vld_q   <= 1'b0;
      mem_rd_addr_q  <= '0;
      mem_wr_vld_q   <= 1'b0;
      mem_wr_addr_q  <= '0;
      mem_wr_data_q  <= '0;
      cons_rd_rdy_q  <= '0;
      // NOTE: the per-consumer read data bank is reset too, since every data output must read 0 out of reset.
      cons_rd_data_q <= '0;
      cons_wr_rdy_q  <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_q        <= grant_d;
      busy_q         <= busy_d;
      mem_rd_vld_q   <= mem_rd_vld_d;
      mem_rd_addr_q  <= mem_rd_addr_d;
      mem_wr_vld_q   <= mem_wr_vld_d;
      mem_wr_addr_q  <= mem_wr_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      cons_rd_rdy_q  <= cons_rd_rdy_d;
      cons_rd_data_q <= cons_rd_data_d;
      cons_wr_rdy_q  <= cons_wr_rdy_d;
    end
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign timeout_error = tmo_err_q;
`else
  assign timeout_error = 1'b0;
`endif

  assign grant_id             = grant_q;
  assign busy                 = busy_q;
  assign mem_read_valid       = mem_rd_vld_q;
  assign mem_read_address     = mem_rd_addr_q;
  assign mem_write_valid      = mem_wr_vld_q;
  assign mem_write_address    = mem_wr_addr_q;
  assign mem_write_data       = mem_wr_data_q;
  assign consumer_read_ready  = cons_rd_rdy_q;
  assign consumer_read_data   = cons_rd_data_q;
  assign consumer_write_ready = cons_wr_rdy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants and completions, a monitor
// pops them as the DUT raises valid/ready; MEM_ARBITER_TIMEOUT_EN selects the watchdog scenario.
module tb_mem_arbiter;

  typedef enum int {EV_ISSUE_RD, EV_ISSUE_WR, EV_DONE_RD, EV_DONE_WR} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int          id;
    logic [7:0]  addr;
    logic [15:0] data;
  } ev_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       consumer_read_valid;
  logic [3:0][7:0]  consumer_read_address;
  logic [3:0]       consumer_read_ready;
  logic [3:0][15:0] consumer_read_data;
  logic [3:0]       consumer_write_valid;
  logic [3:0][7:0]  consumer_write_address;
  logic [3:0][15:0] consumer_write_data;
  logic [3:0]       consumer_write_ready;
  logic             mem_read_valid;
  logic [7:0]       mem_read_address;
  logic             mem_read_ready;
  logic [15:0]      mem_read_data;
  logic             mem_write_valid;
  logic [7:0]       mem_write_address;
  logic [15:0]      mem_write_data;
  logic             mem_write_ready;
  logic [1:0]       grant_id;
  logic             busy;
  logic             timeout_error;

  int   checks = 0;
  int   errors = 0;
  ev_t  sb_q[$];

  // Memory responder knobs, owned by the stimulus process.
  int          mem_delay = 1;
  logic        force_rd_ready = 1'b0;
  logic        rd_override_en = 1'b0;
  logic [15:0] rd_override = 16'h0;

  // Consumer behaviour inside tick(): drop valid on ready, optionally re-raise once per credit.
  logic       auto_drop = 1'b0;
  logic [3:0] pend_raise = '0;
  int         reraise[4] = '{default: 0};

  mem_arbiter #(
    .ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(consumer_read_valid), .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
    .consumer_write_valid(consumer_write_valid), .consumer_write_address(consumer_write_address),
    .consumer_write_data(consumer_write_data), .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .grant_id(grant_id), .busy(busy), .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_e k, input int id, input logic [7:0] a, input logic [15:0] d);
    ev_t e;
    e = '{kind: k, id: id, addr: a, data: d};
    sb_q.push_back(e);
  endtask

  task automatic sb_compare(input ev_kind_e k, input int id, input logic [7:0] a, input logic [15:0] d);
    ev_t e;
    if (sb_q.size() == 0) begin
      check({"sb_unexpected_", k.name()}, 64'(sb_q.size()), 64'd1);
      return;
    end
    e = sb_q.pop_front();
    check({"sb_kind_", e.kind.name()}, 64'(k), 64'(e.kind));
    check({"sb_id_", e.kind.name()}, 64'(id), 64'(e.id));
    if (e.kind == EV_ISSUE_RD || e.kind == EV_ISSUE_WR)
      check({"sb_addr_", e.kind.name()}, 64'(a), 64'(e.addr));
    if (e.kind == EV_ISSUE_WR || e.kind == EV_DONE_RD)
      check({"sb_data_", e.kind.name()}, 64'(d), 64'(e.data));
  endtask

  // Memory model: counts cycles of an outstanding request, then answers with one ready pulse.
  logic [15:0] mem [256];
  int          rsp_cnt;
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'(32'h1000 + i);
      rsp_cnt         = 0;
      mem_read_ready  = force_rd_ready;
      mem_read_data   = 16'hDEAD;
      mem_write_ready = 1'b0;
    end else begin
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      if (mem_read_valid || mem_write_valid) begin
        rsp_cnt++;
        if (rsp_cnt >= mem_delay) begin
          if (mem_read_valid) begin
            mem_read_ready = 1'b1;
            mem_read_data  = rd_override_en ? rd_override : mem[mem_read_address];
          end else begin
            mem_write_ready = 1'b1;
            mem[mem_write_address] = mem_write_data;
          end
        end
      end else begin
        rsp_cnt = 0;
      end
    end
  end

  // Monitor: every rising valid/ready is matched against the head of the scoreboard.
  logic       prev_mrv = 1'b0, prev_mwv = 1'b0;
  logic [3:0] prev_crr = '0, prev_cwr = '0;
  always @(negedge clk) begin
    if (!reset) begin
      check("one_outstanding", 64'(mem_read_valid & mem_write_valid), 64'd0);
      if (mem_read_valid && !prev_mrv)
        sb_compare(EV_ISSUE_RD, int'(grant_id), mem_read_address, 16'h0);
      if (mem_write_valid && !prev_mwv)
        sb_compare(EV_ISSUE_WR, int'(grant_id), mem_write_address, mem_write_data);
      for (int i = 0; i < 4; i++) begin
        if (consumer_read_ready[i] && !prev_crr[i])
          sb_compare(EV_DONE_RD, i, 8'h0, consumer_read_data[i]);
        if (consumer_write_ready[i] && !prev_cwr[i])
          sb_compare(EV_DONE_WR, i, 8'h0, 16'h0);
      end
    end
    prev_mrv = mem_read_valid;
    prev_mwv = mem_write_valid;
    prev_crr = consumer_read_ready;
    prev_cwr = consumer_write_ready;
  end

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (pend_raise[i]) begin
        consumer_read_valid[i] = 1'b1;
        pend_raise[i] = 1'b0;
      end
      if (auto_drop) begin
        if (consumer_read_ready[i] && consumer_read_valid[i]) begin
          consumer_read_valid[i] = 1'b0;
          if (reraise[i] > 0) begin
            reraise[i]--;
            pend_raise[i] = 1'b1;
          end
        end
        if (consumer_write_ready[i] && consumer_write_valid[i])
          consumer_write_valid[i] = 1'b0;
      end
    end
  endtask

  function automatic logic probe(input int sel, input int i);
    case (sel)
      0:       return mem_read_valid;
      1:       return mem_write_valid;
      2:       return consumer_read_ready[i];
      default: return timeout_error;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int i, input int max, input string name);
    int n = 0;
    while (!probe(sel, i) && n < max) begin
      tick();
      n++;
    end
    check(name, 64'(probe(sel, i)), 64'd1);
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < max) begin
      tick();
      n++;
    end
    check({name, "_pending"}, 64'(sb_q.size()), 64'd0);
    check({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit idle_seen;
    bit rd_done;
    reset                  = 1'b1;
    consumer_read_valid    = '0;
    consumer_read_address  = '0;
    consumer_write_valid   = '0;
    consumer_write_address = '0;
    consumer_write_data    = '0;

    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    check("rst_mem_valids", 64'({mem_read_valid, mem_write_valid}), 64'd0);
    check("rst_mem_addr_data", 64'({mem_read_address, mem_write_address, mem_write_data}), 64'd0);
    check("rst_cons_ready", 64'({consumer_read_ready, consumer_write_ready}), 64'd0);
    check("rst_cons_data", consumer_read_data, 64'd0);
    check("rst_timeout", 64'(timeout_error), 64'd0);
    reset = 1'b0;
    tick();

    // Consumer 2 reads 0x15, memory answers 0xBEEF after 3 cycles; consumer holds valid a while.
    mem_delay      = 3;
    rd_override_en = 1'b1;
    rd_override    = 16'hBEEF;
    push(EV_ISSUE_RD, 2, 8'h15, 16'h0);
    push(EV_DONE_RD, 2, 8'h0, 16'hBEEF);
    consumer_read_address[2] = 8'h15;
    consumer_read_valid[2]   = 1'b1;
    wait_for(0, 0, 10, "t036_issue");
    consumer_read_address[2] = 8'h77;
    tick();
    check("t036_addr_latched", 64'(mem_read_address), 64'h15);
    check("t036_busy", 64'(busy), 64'd1);
    wait_for(2, 2, 10, "t036_done");
    repeat (3) begin
      tick();
      check("t036_ready_held", 64'(consumer_read_ready[2]), 64'd1);
    end
    consumer_read_valid[2] = 1'b0;
    tick();
    check("t036_ready_drop", 64'(consumer_read_ready[2]), 64'd0);
    check("t036_idle", 64'(busy), 64'd0);
    check("t036_data_hold", 64'(consumer_read_data[2]), 64'hBEEF);
    rd_override_en = 1'b0;

    // Reset while consumer 1's read is waiting, with memory ready forced high during reset.
    mem_delay = 20;
    push(EV_ISSUE_RD, 1, 8'h30, 16'h0);
    consumer_read_address[1] = 8'h30;
    consumer_read_valid[1]   = 1'b1;
    wait_for(0, 0, 10, "t039_issue");
    repeat (3) tick();
    check("t039_waiting", 64'(mem_read_valid), 64'd1);
    reset                  = 1'b1;
    force_rd_ready         = 1'b1;
    consumer_read_valid[1] = 1'b0;
    tick();
    check("t039_rst_busy", 64'(busy), 64'd0);
    check("t039_rst_mrv", 64'(mem_read_valid), 64'd0);
    check("t039_rst_grant", 64'(grant_id), 64'd0);
    check("t039_rst_data", consumer_read_data, 64'd0);
    tick();
    reset          = 1'b0;
    force_rd_ready = 1'b0;
    tick();
    check("t039_post_busy", 64'(busy), 64'd0);
    check("t039_post_ready", 64'(consumer_read_ready), 64'd0);
    check("t039_post_data", consumer_read_data, 64'd0);
    auto_drop = 1'b1;
    mem_delay = 2;
    push(EV_ISSUE_RD, 0, 8'h01, 16'h0);
    push(EV_DONE_RD, 0, 8'h0, 16'h1001);
    consumer_read_address[0] = 8'h01;
    consumer_read_valid[0]   = 1'b1;
    drain("t039_served", 40);

    // Consumer 1 asserts read 0x10 and write 0x20/0x1234 together; then read 0x20 back.
    push(EV_ISSUE_RD, 1, 8'h10, 16'h0);
    push(EV_DONE_RD, 1, 8'h0, 16'h1010);
    push(EV_ISSUE_WR, 1, 8'h20, 16'h1234);
    push(EV_DONE_WR, 1, 8'h0, 16'h0);
    consumer_read_address[1]  = 8'h10;
    consumer_write_address[1] = 8'h20;
    consumer_write_data[1]    = 16'h1234;
    consumer_read_valid[1]    = 1'b1;
    consumer_write_valid[1]   = 1'b1;
    drain("t038_rd_then_wr", 60);
    push(EV_ISSUE_RD, 0, 8'h20, 16'h0);
    push(EV_DONE_RD, 0, 8'h0, 16'h1234);
    consumer_read_address[0] = 8'h20;
    consumer_read_valid[0]   = 1'b1;
    drain("t038_readback", 40);

    // All four consumers read continuously: grants 0,1,2,3,0,1,2,3.
    reset = 1'b1;
    repeat (2) tick();
    reset     = 1'b0;
    mem_delay = 1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        push(EV_ISSUE_RD, i, 8'(8'h40 + i), 16'h0);
        push(EV_DONE_RD, i, 8'h0, 16'(16'h1040 + i));
      end
    end
    for (int i = 0; i < 4; i++) begin
      reraise[i] = 1;
      consumer_read_address[i] = 8'(8'h40 + i);
    end
    consumer_read_valid = 4'hF;
    drain("t037_round_robin", 200);

    // Consumer 3 write arrives while consumer 0 read is pending.
    mem_delay = 4;
    push(EV_ISSUE_RD, 0, 8'h05, 16'h0);
    push(EV_DONE_RD, 0, 8'h0, 16'h1005);
    push(EV_ISSUE_WR, 3, 8'h06, 16'hCAFE);
    push(EV_DONE_WR, 3, 8'h0, 16'h0);
    consumer_read_address[0] = 8'h05;
    consumer_read_valid[0]   = 1'b1;
    wait_for(0, 0, 10, "t041_rd_issue");
    consumer_write_address[3] = 8'h06;
    consumer_write_data[3]    = 16'hCAFE;
    consumer_write_valid[3]   = 1'b1;
    idle_seen = 1'b0;
    rd_done   = 1'b0;
    for (int n = 0; n < 40 && !mem_write_valid; n++) begin
      tick();
      if (consumer_read_ready[0]) rd_done = 1'b1;
      if (rd_done && !busy) idle_seen = 1'b1;
    end
    check("t041_wr_issued", 64'(mem_write_valid), 64'd1);
    check("t041_idle_before_write", 64'(idle_seen), 64'd1);
    drain("t041_drain", 40);

`ifdef MEM_ARBITER_TIMEOUT_EN
    // Memory never answers: watchdog fires 8 cycles after issue with zero data.
    mem_delay = 1000;
    push(EV_ISSUE_RD, 2, 8'h33, 16'h0);
    push(EV_DONE_RD, 2, 8'h0, 16'h0);
    consumer_read_address[2] = 8'h33;
    consumer_read_valid[2]   = 1'b1;
    wait_for(0, 0, 10, "t040_issue");
    begin
      int k = 0;
      while (!timeout_error && k < 20) begin
        tick();
        k++;
      end
      check("t040_latency", 64'(k), 64'd8);
    end
    check("t040_ready", 64'(consumer_read_ready[2]), 64'd1);
    check("t040_data", 64'(consumer_read_data[2]), 64'd0);
    check("t040_mrv_drop", 64'(mem_read_valid), 64'd0);
    tick();
    check("t040_pulse_width", 64'(timeout_error), 64'd0);
    drain("t040_drain", 20);
`else
    // Without the watchdog a slow memory is simply waited for.
    mem_delay = 30;
    push(EV_ISSUE_RD, 2, 8'h33, 16'h0);
    push(EV_DONE_RD, 2, 8'h0, 16'h1033);
    consumer_read_address[2] = 8'h33;
    consumer_read_valid[2]   = 1'b1;
    wait_for(0, 0, 10, "t035_issue");
    repeat (20) tick();
    check("t035_still_waiting", 64'({busy, mem_read_valid}), 64'h3);
    check("t035_no_timeout", 64'(timeout_error), 64'd0);
    drain("t035_drain", 60);
`endif

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
